reg_file_sb: RTL and testbench

Parametrised successor to the single-write RV64I register file. Provides NUM_RD asynchronous read ports, NUM_WR posedge write ports with write-through bypass, synchronous clear of architectural state, and a per-register busy scoreboard for the issue stage's RAW-hazard checks. Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_scoreboard.sv | 41 ++++
 rtl/reg_file_sb.sv | 93 +++++++++
 tb/tb_reg_file_sb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int XLEN_DEF     = 64;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_IDX_W    = $clog2(NUM_REGS_DEF);
  localparam int ZERO_REG_IDX = 0;
  localparam int MAX_WR       = 4;
  localparam int WR_SEL_W     = 2;

  // Index of the highest-numbered set bit in a write-port match vector.
  function automatic logic [WR_SEL_W-1:0] hi_wr_port(input logic [MAX_WR-1:0] match);
    logic [WR_SEL_W-1:0] sel;
    sel = '0;
    for (int w = 0; w < MAX_WR; w++) begin
      if (match[w]) sel = WR_SEL_W'(w);
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, set wins on collision.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                iss_en_i,
  input  logic [IDX_W-1:0]    iss_idx_i,
  input  logic [NUM_REGS-1:0] clr_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (iss_en_i && (iss_idx_i == IDX_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (clr_i[i]) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[ZERO_REG_IDX] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with optional write-through bypass and RAW scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_ao,
  output logic [NUM_RD-1:0]        rd_busy_ao,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*IDX_W-1:0]  wr_idx_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  input  logic                     iss_en_i,
  input  logic [IDX_W-1:0]         iss_idx_i,
  output logic [NUM_REGS-1:0]      busy_vec_o
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [MAX_WR-1:0]   wr_hit [NUM_REGS];
  logic [XLEN-1:0]     wr_win [NUM_REGS];
  logic [NUM_REGS-1:0] wr_clr;

  // Per-register write decode; the winning port's data doubles as the bypass value.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        wr_hit[r][w] = wr_en_i[w] && (wr_idx_i[w*IDX_W +: IDX_W] == IDX_W'(r));
      end
      if (r == ZERO_REG_IDX) wr_hit[r] = '0;
      wr_clr[r] = |wr_hit[r];
      wr_win[r] = wr_data_i[int'(hi_wr_port(wr_hit[r]))*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_clr[r]) regs_q[r] <= wr_win[r];
      end
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .iss_en_i  (iss_en_i),
    .iss_idx_i (iss_idx_i),
    .clr_i     (wr_clr),
    .busy_o    (busy_vec_o)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [IDX_W-1:0] idx;
      logic [XLEN-1:0]  data;
      logic             busy;

      assign idx = rd_idx_i[gi*IDX_W +: IDX_W];

      // A completing write is forwarded, so its scoreboard entry no longer blocks the reader.
      always_comb begin
        data = regs_q[idx];
        busy = busy_vec_o[idx];
        if ((BYPASS != 0) && wr_clr[idx]) begin
          data = wr_win[idx];
          busy = 1'b0;
        end
        if (idx == IDX_W'(ZERO_REG_IDX)) begin
          data = '0;
          busy = 1'b0;
        end
      end

      assign rd_data_ao[gi*XLEN +: XLEN] = data;
      assign rd_busy_ao[gi]              = busy;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Drives a bypassing and a non-bypassing two-write-port instance with identical stimulus.
module tb_reg_file_sb;

  localparam int XL  = 64;
  localparam int NR  = 32;
  localparam int IW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NRD*IW-1:0]   rd_idx;
  logic [NWR-1:0]      wr_en;
  logic [NWR*IW-1:0]   wr_idx;
  logic [NWR*XL-1:0]   wr_data;
  logic                iss_en;
  logic [IW-1:0]       iss_idx;
  logic [NRD*XL-1:0]   rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic [NR-1:0]       bvec_b, bvec_n;

  reg_file_sb #(.XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .rd_idx_i(rd_idx), .rd_data_ao(rd_data_b), .rd_busy_ao(rd_busy_b),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .iss_en_i(iss_en),
    .iss_idx_i(iss_idx), .busy_vec_o(bvec_b)
  );

  reg_file_sb #(.XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) dut_n (
    .clk_i(clk), .rst_i(rst), .rd_idx_i(rd_idx), .rd_data_ao(rd_data_n), .rd_busy_ao(rd_busy_n),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .iss_en_i(iss_en),
    .iss_idx_i(iss_idx), .busy_vec_o(bvec_n)
  );

  logic [XL-1:0] m_reg [NR];
  bit            m_busy [NR];
  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rst;
    bit [1:0]    wen;
    int          wi0, wi1;
    logic [63:0] wd0, wd1;
    bit          iss;
    int          ii;
    int          ri0, ri1;
    logic [63:0] eb, en;
    bit          bb, bn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit r, bit [1:0] we, int w0, int w1, logic [63:0] d0, logic [63:0] d1,
                             bit is, int ix, int r0, int r1, logic [63:0] eb, logic [63:0] en,
                             bit bb, bit bn);
    vec_t t;
    t.rst = r; t.wen = we; t.wi0 = w0; t.wi1 = w1; t.wd0 = d0; t.wd1 = d1;
    t.iss = is; t.ii = ix; t.ri0 = r0; t.ri1 = r1; t.eb = eb; t.en = en; t.bb = bb; t.bn = bn;
    return t;
  endfunction

  task automatic chk(string name, int dut, int port, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d port=%0d got=%h exp=%h", name, dut, port, got, exp);
    end
  endtask

  // Value a reader should see this cycle: x0 is zero, bypass takes the last enabled writer.
  function automatic logic [63:0] exp_rd(int idx, bit byp);
    logic [63:0] d;
    if (idx == 0) return 64'd0;
    d = m_reg[idx];
    if (byp) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && int'(wr_idx[w*IW +: IW]) == idx) d = wr_data[w*XL +: XL];
      end
    end
    return d;
  endfunction

  function automatic bit exp_bsy(int idx, bit byp);
    if (idx == 0) return 1'b0;
    if (byp) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && int'(wr_idx[w*IW +: IW]) == idx) return 1'b0;
      end
    end
    return m_busy[idx];
  endfunction

  task automatic check_model();
    logic [NR-1:0] ev;
    for (int p = 0; p < NRD; p++) begin
      int idx;
      idx = int'(rd_idx[p*IW +: IW]);
      chk("rd_data", 0, p, rd_data_b[p*XL +: XL], exp_rd(idx, 1'b1));
      chk("rd_data", 1, p, rd_data_n[p*XL +: XL], exp_rd(idx, 1'b0));
      chk("rd_busy", 0, p, 64'(rd_busy_b[p]), 64'(exp_bsy(idx, 1'b1)));
      chk("rd_busy", 1, p, 64'(rd_busy_n[p]), 64'(exp_bsy(idx, 1'b0)));
    end
    for (int i = 0; i < NR; i++) ev[i] = m_busy[i];
    chk("busy_vec", 0, 0, 64'(bvec_b), 64'(ev));
    chk("busy_vec", 1, 0, 64'(bvec_n), 64'(ev));
  endtask

  // Writes land in port order (later port overwrites), then clears, then issue wins.
  task automatic update_model();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        int ix;
        ix = int'(wr_idx[w*IW +: IW]);
        if (wr_en[w] && ix != 0) begin
          m_reg[ix] = wr_data[w*XL +: XL];
          m_busy[ix] = 1'b0;
        end
      end
      if (iss_en && iss_idx != '0) m_busy[int'(iss_idx)] = 1'b1;
    end
  endtask

  task automatic finish_cycle();
    check_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = '0; wr_idx = '0; wr_data = '0; iss_en = 1'b0; iss_idx = '0; rd_idx = '0;
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    tbl.push_back(v(0, 2'b01, 4, 0, 64'hAA, 0, 1, 4, 4, 1, 64'hAA, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 5, 6, '1, '1, 1, 7, 4, 5, 64'hAA, 64'hAA, 1, 1));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 5, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b01, 5, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 5, 4, 64'h0123_4567_89AB_CDEF, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 0));
    tbl.push_back(v(0, 2'b01, 0, 0, 64'hDEAD, 0, 1, 0, 0, 5, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b11, 7, 7, 64'h11, 64'h22, 0, 0, 7, 0, 64'h22, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 64'h22, 64'h22, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 2'b01, 9, 0, 64'h42, 0, 0, 0, 9, 0, 64'h42, 0, 0, 1));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 64'h42, 64'h42, 0, 0));
    tbl.push_back(v(0, 2'b01, 3, 0, 64'h5, 0, 1, 3, 3, 9, 64'h5, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0, 64'h5, 64'h5, 1, 1));
    tbl.push_back(v(0, 2'b10, 0, 3, 0, 64'h6, 0, 0, 3, 0, 64'h6, 64'h5, 0, 1));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0, 64'h6, 64'h6, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      rst     = tbl[k].rst;
      wr_en   = tbl[k].wen;
      wr_idx  = {IW'(tbl[k].wi1), IW'(tbl[k].wi0)};
      wr_data = {tbl[k].wd1, tbl[k].wd0};
      iss_en  = tbl[k].iss;
      iss_idx = IW'(tbl[k].ii);
      rd_idx  = {IW'(tbl[k].ri1), IW'(tbl[k].ri0)};
      #1;
      chk("vec_data", 0, k, rd_data_b[XL-1:0], tbl[k].eb);
      chk("vec_data", 1, k, rd_data_n[XL-1:0], tbl[k].en);
      chk("vec_busy", 0, k, 64'(rd_busy_b[0]), 64'(tbl[k].bb));
      chk("vec_busy", 1, k, 64'(rd_busy_n[0]), 64'(tbl[k].bn));
      $display("vec %0d: rd0 b=%h n=%h busy b=%0b n=%0b", k, rd_data_b[XL-1:0],
               rd_data_n[XL-1:0], rd_busy_b[0], rd_busy_n[0]);
      finish_cycle();
    end

    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom_range(0, 63) == 0);
      wr_en   = NWR'($urandom);
      for (int w = 0; w < NWR; w++) begin
        wr_idx[w*IW +: IW]  = IW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR-1) : $urandom_range(0, 7));
        wr_data[w*XL +: XL] = {$urandom, $urandom};
      end
      for (int p = 0; p < NRD; p++) rd_idx[p*IW +: IW] = IW'($urandom_range(0, 7));
      iss_en  = 1'($urandom);
      iss_idx = IW'($urandom_range(0, 7));
      #1;
      $display("rnd %0d: rst=%0b wen=%b widx=%h iss=%0b/%0d ridx=%h", k, rst, wr_en, wr_idx,
               iss_en, iss_idx, rd_idx);
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
